riscv_trap_seq: RTL and testbench
=================================

# riscv_trap_seq

Machine-mode trap sequencer for the RV32 core. It sits between the pipeline and the CSR file and shares the CSR file's single access port with the pipeline through a request/grant handshake. On an exception, an enabled interrupt or an MRET, it stalls the pipeline and performs the required CSR accesses in order (MIE, MEPC, MCAUSE, MTVEC). It then issues a one-cycle PC redirect.

## Interface
- XLEN, 32, data and PC width
- ADDR_W, 12, CSR address width
- clk_i  in  1  core clock
- arst_i  in  1  reset; asynchronous, active-high
- irq_timer_i  in  1  machine timer interrupt, level
- irq_ext_i  in  1  machine external interrupt, level
- exc_valid_i  in  1  synchronous exception pulse
- exc_cause_i  in  5  exception code
- exc_pc_i  in  XLEN  PC of the faulting instruction
- mret_i  in  1  MRET retire pulse
- next_pc_i  in  XLEN  PC of the next unexecuted instruction (MEPC for interrupts)
- stall_o  out  1  holds the pipeline while a sequence runs
- csr_req_o  out  1  CSR port request
- csr_we_o  out  1  1 = write, 0 = read
- csr_addr_o  out  ADDR_W  CSR address
- csr_wdata_o  out  XLEN  write data
- csr_rdata_i  in  XLEN  read data, valid in the grant cycle
- csr_gnt_i  in  1  CSR port grant
- redirect_o  out  1  one-cycle PC redirect strobe
- redirect_pc_o  out  XLEN  redirect target

## Operation
- FSM states: IDLE, RD_MIE, WR_MEPC, WR_MCAUSE, RD_MTVEC, RD_MEPC, REDIRECT.
- Internal flag `in_trap`: reset 0; set on entering WR_MEPC; cleared on the MRET redirect.
- Events are sampled only in IDLE. Priority order:
  - exc_valid_i
  - mret_i
  - irq_ext_i (only if !in_trap)
  - irq_timer_i (only if !in_trap)
- Event-to-state mapping:
  - Exception: latch MEPC ← exc_pc_i, cause ← {27'b0, exc_cause_i}, then go to WR_MEPC.
  - Interrupt: latch MEPC ← next_pc_i, go to RD_MIE.
    - External cause = 0x8000000B; timer cause = 0x80000007.
  - MRET: go to RD_MEPC.
- RD_MIE:
  - Read 0x304.
  - Interrupt is enabled if (ext and rdata[11]) or (timer and rdata[7]); the latched source is used.
  - Enabled → WR_MEPC. Disabled → IDLE with no writes and no redirect.
- WR_MEPC: write 0x341 with the latched MEPC.
- WR_MCAUSE: write 0x342 with the latched cause.
- RD_MTVEC: read 0x305 and compute the target:
  - Base = rdata & ~3.
  - Target = base, or base + 4·(cause[4:0]) (see Configuration).
  - Addition is modulo 2^XLEN.
- RD_MEPC: read 0x341; target = rdata & ~1.
- REDIRECT: redirect_o = 1 and redirect_pc_o = target for exactly one cycle, then IDLE.
- CSR handshake:
  - In every CSR state, csr_req_o = 1 and addr/we/wdata are held stable.
  - The state advances only in a cycle where csr_gnt_i = 1; rdata is captured in that same cycle.
  - csr_req_o = 0 in IDLE and REDIRECT.
- stall_o = (state != IDLE). It is combinational from state.
- Pulses arriving outside IDLE are ignored, since the core is stalled and cannot produce them.
- Simultaneous events:
  - exc + irq → exception.
  - exc + mret → exception.
  - mret + irq → MRET.

## Timing
- Reset values: stall_o 0, csr_req_o 0, csr_we_o 0, csr_addr_o 0, csr_wdata_o 0, redirect_o 0, redirect_pc_o 0, in_trap 0, state IDLE.
- Latencies with csr_gnt_i tied high (event sampled at edge N):
  - Exception: redirect_o high in cycle N+4.
  - Enabled interrupt: redirect_o high in cycle N+5.
  - MRET: redirect_o high in cycle N+2.
  - Masked interrupt: stall_o high for 1 cycle only.
- Each cycle csr_gnt_i is low adds one cycle of latency.
- Reset asserted mid-sequence:
  - Immediately returns to IDLE and clears in_trap.
  - CSR writes already granted are not undone.
  - No redirect is issued.

## Configuration
- `RISCV_TRAP_VECTORED_EN` defined:
  - mtvec[1:0] = 1 selects vectored mode for interrupts: target = base + 4·cause[4:0].
  - Exceptions always use base.
- Not defined:
  - mtvec[1:0] is ignored; all traps go to base (direct mode only).
  - The adder is removed.

## Test plan
- Exception, gnt tied high: exc_cause_i = 2, exc_pc_i = 0x100, MTVEC = 0x200.
  - Required: writes MEPC = 0x100 and MCAUSE = 0x2.
  - Required: redirect_pc_o = 0x200 at N+4; stall_o high for 4 cycles.
- Timer interrupt: MIE = 0x80, next_pc_i = 0x44, MTVEC = 0x201.
  - Required: MCAUSE = 0x80000007.
  - Required with `RISCV_TRAP_VECTORED_EN`: redirect_pc_o = 0x21C; without it: 0x200.
- Masked external interrupt: MIE = 0.
  - Required: one MIE read, no writes, no redirect, back in IDLE.
- MRET: MEPC = 0x101.
  - Required: redirect_pc_o = 0x100 at N+2; in_trap cleared, so a pending timer interrupt is then taken.
- Grant back-pressure: csr_gnt_i low 3 cycles in WR_MCAUSE.
  - Required: addr 0x342 and wdata held stable throughout; redirect delayed by exactly 3 cycles.
- Simultaneous and reset cases:
  - exc_valid_i + irq_ext_i + mret_i together → exception sequence only.
  - arst_i pulsed during RD_MTVEC → all outputs at reset values, no redirect.

Source files
------------

// File: rtl/riscv_trap_seq.sv
// riscv_trap_seq: machine-mode trap sequencer for the RV32 core.
//
// On an exception, an enabled interrupt or an MRET it stalls the pipeline, walks the needed CSR
// accesses over the shared CSR port (request/grant), then issues a one-cycle PC redirect.
//
// Ports:
//   clk_i, arst_i             clock, asynchronous active-high reset
//   irq_timer_i, irq_ext_i    level interrupts (taken only when not already in a trap)
//   exc_valid_i/cause/pc      synchronous exception pulse, code and faulting PC
//   mret_i                    MRET retire pulse
//   next_pc_i                 PC of next unexecuted instruction (MEPC for interrupts)
//   stall_o                   high whenever a sequence is running
//   csr_req_o/we/addr/wdata   CSR port request, held stable until csr_gnt_i
//   csr_rdata_i, csr_gnt_i    CSR read data (valid in the grant cycle) and grant
//   redirect_o/redirect_pc_o  one-cycle redirect strobe and target
//
// Build option: define RISCV_TRAP_VECTORED_EN to honour mtvec vectored mode (mtvec[1:0] = 1) for
// interrupts. Without it every trap goes to the mtvec base.
module riscv_trap_seq #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              irq_timer_i,
    input  logic              irq_ext_i,
    input  logic              exc_valid_i,
    input  logic [4:0]        exc_cause_i,
    input  logic [XLEN-1:0]   exc_pc_i,
    input  logic              mret_i,
    input  logic [XLEN-1:0]   next_pc_i,
    output logic              stall_o,
    output logic              csr_req_o,
    output logic              csr_we_o,
    output logic [ADDR_W-1:0] csr_addr_o,
    output logic [XLEN-1:0]   csr_wdata_o,
    input  logic [XLEN-1:0]   csr_rdata_i,
    input  logic              csr_gnt_i,
    output logic              redirect_o,
    output logic [XLEN-1:0]   redirect_pc_o
);

    localparam logic [ADDR_W-1:0] CsrMie   = ADDR_W'(12'h304);
    localparam logic [ADDR_W-1:0] CsrMtvec = ADDR_W'(12'h305);
    localparam logic [ADDR_W-1:0] CsrMepc  = ADDR_W'(12'h341);
    localparam logic [ADDR_W-1:0] CsrMcause = ADDR_W'(12'h342);

    localparam logic [XLEN-1:0] IrqExtCause   = {1'b1, {(XLEN-5){1'b0}}, 4'hB};
    localparam logic [XLEN-1:0] IrqTimerCause = {1'b1, {(XLEN-5){1'b0}}, 4'h7};

    typedef enum logic [2:0] {
        StIdle,
        StRdMie,
        StWrMepc,
        StWrMcause,
        StRdMtvec,
        StRdMepc,
        StRedirect
    } state_e;

    state_e            state_q, state_d;
    logic              in_trap_q, in_trap_d;
    logic              src_ext_q, src_ext_d;
    logic              is_mret_q, is_mret_d;
    logic [XLEN-1:0]   mepc_q, mepc_d;
    logic [XLEN-1:0]   cause_q, cause_d;
    logic [XLEN-1:0]   target_q, target_d;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q   <= StIdle;
            in_trap_q <= 1'b0;
            src_ext_q <= 1'b0;
            is_mret_q <= 1'b0;
            mepc_q    <= '0;
            cause_q   <= '0;
            target_q  <= '0;
        end else begin
            state_q   <= state_d;
            in_trap_q <= in_trap_d;
            src_ext_q <= src_ext_d;
            is_mret_q <= is_mret_d;
            mepc_q    <= mepc_d;
            cause_q   <= cause_d;
            target_q  <= target_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_trap_d = in_trap_q;
        src_ext_d = src_ext_q;
        is_mret_d = is_mret_q;
        mepc_d    = mepc_q;
        cause_d   = cause_q;
        target_d  = target_q;

        stall_o       = (state_q != StIdle);
        csr_req_o     = 1'b0;
        csr_we_o      = 1'b0;
        csr_addr_o    = '0;
        csr_wdata_o   = '0;
        redirect_o    = 1'b0;
        redirect_pc_o = '0;

        unique case (state_q)
            StIdle: begin
                if (exc_valid_i) begin
                    mepc_d    = exc_pc_i;
                    cause_d   = XLEN'(exc_cause_i);
                    is_mret_d = 1'b0;
                    in_trap_d = 1'b1;
                    state_d   = StWrMepc;
                end else if (mret_i) begin
                    is_mret_d = 1'b1;
                    state_d   = StRdMepc;
                end else if (!in_trap_q && (irq_ext_i || irq_timer_i)) begin
                    // External wins over timer when both are pending.
                    mepc_d    = next_pc_i;
                    src_ext_d = irq_ext_i;
                    cause_d   = irq_ext_i ? IrqExtCause : IrqTimerCause;
                    is_mret_d = 1'b0;
                    state_d   = StRdMie;
                end
            end
            StRdMie: begin
                csr_req_o  = 1'b1;
                csr_addr_o = CsrMie;
                if (csr_gnt_i) begin
                    if ((src_ext_q && csr_rdata_i[11]) || (!src_ext_q && csr_rdata_i[7])) begin
                        in_trap_d = 1'b1;
                        state_d   = StWrMepc;
                    end else begin
                        // Masked: drop the interrupt silently.
                        state_d = StIdle;
                    end
                end
            end
            StWrMepc: begin
                csr_req_o   = 1'b1;
                csr_we_o    = 1'b1;
                csr_addr_o  = CsrMepc;
                csr_wdata_o = mepc_q;
                if (csr_gnt_i) state_d = StWrMcause;
            end
            StWrMcause: begin
                csr_req_o   = 1'b1;
                csr_we_o    = 1'b1;
                csr_addr_o  = CsrMcause;
                csr_wdata_o = cause_q;
                if (csr_gnt_i) state_d = StRdMtvec;
            end
            StRdMtvec: begin
                csr_req_o  = 1'b1;
                csr_addr_o = CsrMtvec;
                if (csr_gnt_i) begin
                    target_d = csr_rdata_i & ~XLEN'(3);
`ifdef RISCV_TRAP_VECTORED_EN
                    // Vectored mode applies to interrupts only (cause MSB set).
                    if (cause_q[XLEN-1] && (csr_rdata_i[1:0] == 2'b01)) begin
                        target_d = (csr_rdata_i & ~XLEN'(3)) + XLEN'({cause_q[4:0], 2'b00});
                    end
`endif
                    state_d = StRedirect;
                end
            end
            StRdMepc: begin
                csr_req_o  = 1'b1;
                csr_addr_o = CsrMepc;
                if (csr_gnt_i) begin
                    target_d = csr_rdata_i & ~XLEN'(1);
                    state_d  = StRedirect;
                end
            end
            StRedirect: begin
                redirect_o    = 1'b1;
                redirect_pc_o = target_q;
                if (is_mret_q) in_trap_d = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_riscv_trap_seq.sv
`timescale 1ns/1ps
module tb_riscv_trap_seq;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        irq_timer = 1'b0, irq_ext = 1'b0, exc_valid = 1'b0, mret = 1'b0;
    logic [4:0]  exc_cause = '0;
    logic [31:0] exc_pc = '0, next_pc = '0;
    logic        stall, csr_req, csr_we, redirect;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata, redirect_pc;
    logic [31:0] csr_rdata = '0;
    logic        csr_gnt = 1'b0;

    always #5 clk = ~clk;

    riscv_trap_seq dut (
        .clk_i        (clk),
        .arst_i       (arst),
        .irq_timer_i  (irq_timer),
        .irq_ext_i    (irq_ext),
        .exc_valid_i  (exc_valid),
        .exc_cause_i  (exc_cause),
        .exc_pc_i     (exc_pc),
        .mret_i       (mret),
        .next_pc_i    (next_pc),
        .stall_o      (stall),
        .csr_req_o    (csr_req),
        .csr_we_o     (csr_we),
        .csr_addr_o   (csr_addr),
        .csr_wdata_o  (csr_wdata),
        .csr_rdata_i  (csr_rdata),
        .csr_gnt_i    (csr_gnt),
        .redirect_o   (redirect),
        .redirect_pc_o(redirect_pc)
    );

    int checks = 0;
    int passes = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
    endtask

    // CSR file model and access log
    typedef struct packed {
        logic        we;
        logic [11:0] addr;
        logic [31:0] data;
    } acc_t;

    logic [31:0] csr_mem [4096];
    acc_t        act_q[$];
    acc_t        exp_q[$];
    int          waits_q[$];
    int          cur_wait = 0;
    bit          loaded = 0;
    logic [11:0] held_addr;
    logic [31:0] held_wdata;

    // Responder: per access, stall the grant for a queued number of cycles, then grant.
    always @(negedge clk) begin
        if (!csr_req || arst) begin
            csr_gnt = 1'b0;
            loaded  = 0;
        end else begin
            if (!loaded) begin
                cur_wait   = (waits_q.size() > 0) ? waits_q.pop_front() : 0;
                loaded     = 1;
                held_addr  = csr_addr;
                held_wdata = csr_wdata;
            end else begin
                check("hold_addr", {20'h0, csr_addr}, {20'h0, held_addr});
                check("hold_wdata", csr_wdata, held_wdata);
            end
            if (cur_wait > 0) begin
                csr_gnt = 1'b0;
                cur_wait--;
            end else begin
                acc_t a;
                csr_gnt   = 1'b1;
                csr_rdata = csr_mem[csr_addr];
                a.we = csr_we; a.addr = csr_addr; a.data = csr_wdata;
                act_q.push_back(a);
                if (csr_we) csr_mem[csr_addr] = csr_wdata;
                loaded = 0;
            end
        end
    end

    // Reference model: architectural trap rules
    bit          m_in_trap = 0;
    bit          exp_redir;
    logic [31:0] exp_target;
    int          exp_stall;

    function automatic acc_t mk(input logic we, input logic [11:0] addr, input logic [31:0] d);
        acc_t a;
        a.we = we; a.addr = addr; a.data = d;
        return a;
    endfunction

    task automatic predict(input bit exc, input logic [4:0] cause, input logic [31:0] pc,
                           input bit mr, input bit ext, input bit tmr, input logic [31:0] npc);
        logic [31:0] icause;
        logic [31:0] tvec;
        exp_q.delete();
        exp_redir  = 0;
        exp_target = 0;
        if (exc) begin
            exp_q.push_back(mk(1, 12'h341, pc));
            exp_q.push_back(mk(1, 12'h342, {27'h0, cause}));
            exp_q.push_back(mk(0, 12'h305, 0));
            exp_target = csr_mem[12'h305] & 32'hFFFF_FFFC;
            exp_redir  = 1;
            m_in_trap  = 1;
        end else if (mr) begin
            exp_q.push_back(mk(0, 12'h341, 0));
            exp_target = csr_mem[12'h341] & 32'hFFFF_FFFE;
            exp_redir  = 1;
            m_in_trap  = 0;
        end else if (!m_in_trap && (ext || tmr)) begin
            icause = ext ? 32'h8000_000B : 32'h8000_0007;
            exp_q.push_back(mk(0, 12'h304, 0));
            if (ext ? csr_mem[12'h304][11] : csr_mem[12'h304][7]) begin
                exp_q.push_back(mk(1, 12'h341, npc));
                exp_q.push_back(mk(1, 12'h342, icause));
                exp_q.push_back(mk(0, 12'h305, 0));
                tvec       = csr_mem[12'h305];
                exp_target = tvec & 32'hFFFF_FFFC;
`ifdef RISCV_TRAP_VECTORED_EN
                if (tvec[1:0] == 2'b01) exp_target = exp_target + 4 * (icause & 32'd31);
`endif
                exp_redir = 1;
                m_in_trap = 1;
            end
        end
        exp_stall = exp_q.size() + (exp_redir ? 1 : 0);
    endtask

    task automatic run_event(input string tag, input bit exc, input logic [4:0] cause,
                             input logic [31:0] pc, input bit mr, input bit ext, input bit tmr,
                             input logic [31:0] npc, input int max_wait, input int wait_idx,
                             input int wait_len);
        int          stall_cnt = 0;
        int          redir_cnt = 0;
        int          redir_cyc = 0;
        logic [31:0] redir_pc = 0;
        bit          done = 0;
        @(negedge clk);
        predict(exc, cause, pc, mr, ext, tmr, npc);
        waits_q.delete();
        act_q.delete();
        for (int i = 0; i < exp_q.size(); i++) begin
            int w;
            w = (i == wait_idx) ? wait_len : ((max_wait > 0) ? int'($urandom_range(max_wait, 0)) : 0);
            waits_q.push_back(w);
            exp_stall += w;
        end
        exc_valid = exc; exc_cause = cause; exc_pc = pc; mret = mr;
        irq_ext = ext; irq_timer = tmr; next_pc = npc;
        @(posedge clk);
        for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
            @(negedge clk);
            exc_valid = 0; mret = 0; irq_ext = 0; irq_timer = 0;
            if (redirect) begin
                redir_cnt++;
                redir_cyc = cyc;
                redir_pc  = redirect_pc;
            end
            if (stall) stall_cnt++;
            else done = 1;
        end
        check({tag, "_timeout"}, {31'h0, done}, 1);
        check({tag, "_stall_cycles"}, stall_cnt, exp_stall);
        check({tag, "_redirect_count"}, redir_cnt, exp_redir ? 1 : 0);
        if (exp_redir) begin
            check({tag, "_redirect_cycle"}, redir_cyc, exp_stall);
            check({tag, "_redirect_pc"}, redir_pc, exp_target);
        end
        check({tag, "_access_count"}, act_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            check({tag, "_acc_we"}, {31'h0, act_q[i].we}, {31'h0, exp_q[i].we});
            check({tag, "_acc_addr"}, {20'h0, act_q[i].addr}, {20'h0, exp_q[i].addr});
            if (exp_q[i].we) check({tag, "_acc_wdata"}, act_q[i].data, exp_q[i].data);
        end
        check({tag, "_idle_req"}, {31'h0, csr_req}, 0);
        waits_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_stall"}, {31'h0, stall}, 0);
        check({tag, "_req"}, {31'h0, csr_req}, 0);
        check({tag, "_we"}, {31'h0, csr_we}, 0);
        check({tag, "_addr"}, {20'h0, csr_addr}, 0);
        check({tag, "_wdata"}, csr_wdata, 0);
        check({tag, "_redirect"}, {31'h0, redirect}, 0);
        check({tag, "_redirect_pc"}, redirect_pc, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int rst_redirects;
        int rst_stalls;
        for (int i = 0; i < 4096; i++) csr_mem[i] = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        arst = 0;
        m_in_trap = 0;

        // Exception, grant tied high
        csr_mem[12'h305] = 32'h200;
        run_event("exc", 1, 5'd2, 32'h100, 0, 0, 0, 0, 0, -1, 0);

        // MRET with a timer pending: MRET wins, then the timer interrupt is taken
        csr_mem[12'h341] = 32'h101;
        run_event("mret", 0, 0, 0, 1, 0, 1, 32'h44, 0, -1, 0);
        csr_mem[12'h304] = 32'h80;
        csr_mem[12'h305] = 32'h201;
        run_event("timer", 0, 0, 0, 0, 0, 1, 32'h44, 0, -1, 0);

        // Leave the trap, then a masked external interrupt
        run_event("mret2", 0, 0, 0, 1, 0, 0, 0, 0, -1, 0);
        csr_mem[12'h304] = 32'h0;
        run_event("masked_ext", 0, 0, 0, 0, 1, 0, 32'h88, 0, -1, 0);

        // Grant held low 3 cycles in WR_MCAUSE
        csr_mem[12'h305] = 32'h400;
        run_event("backpressure", 1, 5'd11, 32'h1234, 0, 0, 0, 0, 0, 1, 3);

        // All three events together: exception only
        run_event("simul", 1, 5'd4, 32'h2000, 1, 1, 0, 32'h3000, 0, -1, 0);

        // Reset in the middle of RD_MTVEC
        csr_mem[12'h305] = 32'h300;
        @(negedge clk);
        act_q.delete();
        waits_q.delete();
        waits_q.push_back(0); waits_q.push_back(0); waits_q.push_back(6);
        exc_valid = 1; exc_cause = 5'd5; exc_pc = 32'h80;
        @(posedge clk);
        @(negedge clk);
        exc_valid = 0;
        repeat (3) @(negedge clk);
        arst = 1;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        arst = 0;
        m_in_trap = 0;
        waits_q.delete();
        rst_redirects = 0;
        rst_stalls = 0;
        repeat (8) begin
            @(negedge clk);
            if (redirect) rst_redirects++;
            if (stall) rst_stalls++;
        end
        check("midreset_no_redirect", rst_redirects, 0);
        check("midreset_idle", rst_stalls, 0);
        check("midreset_writes_kept", act_q.size(), 2);

        // in_trap cleared by reset: an enabled timer interrupt is taken
        csr_mem[12'h304] = 32'h80;
        csr_mem[12'h305] = 32'h500;
        run_event("post_reset_timer", 0, 0, 0, 0, 0, 1, 32'h600, 0, -1, 0);

        // Randomized events against the model
        for (int n = 0; n < 40; n++) begin
            bit e, m, x, t;
            e = ($urandom_range(0, 3) == 0);
            m = ($urandom_range(0, 3) == 0);
            x = $urandom_range(0, 1);
            t = $urandom_range(0, 1);
            csr_mem[12'h304] = $urandom & 32'h0000_0880;
            csr_mem[12'h305] = $urandom;
            if ($urandom_range(0, 1) == 1) csr_mem[12'h341] = $urandom;
            run_event("rand", e, 5'($urandom), $urandom, m, x, t, $urandom, 2, -1, 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
